onoff_fsm: RTL and testbench

ONOFF_FSM -- requirements
Module: onoff_fsm

---
 rtl/onoff_fsm.sv | 121 ++++++++++++
 tb/tb_onoff_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/onoff_fsm.sv
// ----------------------------------------------------------------------------
// onoff_fsm
//
// Push-button on/off toggle. The raw button level is synchronized into the
// clock domain, debounced by a run-length counter, and then fed to a
// four-state machine that toggles the output once per debounced press.
// Holding or releasing the button never changes the output.
//
// Parameters
//   DB_CYCLES : consecutive clocks the synchronized level must disagree
//               with the debounced level before the debounced level
//               follows it (1..255).
//
// Ports
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high reset
//   sw    : raw asynchronous push-button level (1 = pressed)
//   out   : registered on/off level (1 = on)
// ----------------------------------------------------------------------------
module onoff_fsm #(
    parameter int DB_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic out
);

    // The counter is 8 bits wide, so the threshold is taken modulo 256.
    localparam logic [7:0] DB_LIM = 8'(DB_CYCLES);

    // One-hot encoding: the twelve non-one-hot codes are all illegal and
    // are caught by the default branch of the next-state decode.
    typedef enum logic [3:0] {
        OFF_RELEASED = 4'b0001,
        ON_HELD      = 4'b0010,
        ON_RELEASED  = 4'b0100,
        OFF_HELD     = 4'b1000
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    logic       r_db;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_inc;
    logic       w_mismatch;
    logic       w_db_take;

    assign w_cnt_inc  = r_cnt + 8'd1;
    assign w_mismatch = (r_sync2 != r_db);
    // The counter never actually holds DB_CYCLES: on the clock it would
    // reach the threshold the debounced level updates and the count clears.
    assign w_db_take  = w_mismatch && (w_cnt_inc == DB_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_db  <= 1'b0;
            r_cnt <= 8'd0;
        end else if (!w_mismatch) begin
            r_cnt <= 8'd0;
        end else if (w_db_take) begin
            r_db  <= r_sync2;
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Toggle FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_out_nxt;
    logic   r_out;

    always_comb begin
        w_state_nxt = OFF_RELEASED;
        case (r_state)
            OFF_RELEASED: w_state_nxt = r_db  ? ON_HELD      : OFF_RELEASED;
            ON_HELD:      w_state_nxt = !r_db ? ON_RELEASED  : ON_HELD;
            ON_RELEASED:  w_state_nxt = r_db  ? OFF_HELD     : ON_RELEASED;
            OFF_HELD:     w_state_nxt = !r_db ? OFF_RELEASED : OFF_HELD;
            default:      w_state_nxt = OFF_RELEASED;
        endcase
    end

    // The output is decoded from the next state so it is registered on
    // the same edge as the state itself, with no path from sw.
    assign w_out_nxt = (w_state_nxt == ON_HELD) || (w_state_nxt == ON_RELEASED);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OFF_RELEASED;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_onoff_fsm.sv
// ----------------------------------------------------------------------------
// tb_onoff_fsm
//
// Directed stimulus for onoff_fsm (DB_CYCLES = 2). A behavioural model
// tracks the button as "delayed by two clocks, accepted after a stable run
// of DB_CYCLES clocks, each accepted press flips the output one clock
// later". One process compares the DUT against that model every cycle;
// directed checks pin both the DUT and the model to hand-derived values.
// ----------------------------------------------------------------------------
module tb_onoff_fsm;

    localparam int DB = 2;

    logic clk;
    logic reset;
    logic sw;
    logic out;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    onoff_fsm #(.DB_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_d1, m_d2;     // button delayed by one and two clocks
    bit m_db;           // accepted (debounced) button level
    int m_run;          // length of current disagreement run
    bit m_seen;         // accepted level at the previous edge
    bit m_out;

    always @(posedge clk) begin
        if (reset) begin
            m_d1 = 0; m_d2 = 0; m_db = 0; m_run = 0; m_seen = 0; m_out = 0;
        end else begin
            // a newly accepted press flips the output one edge later
            if (m_db && !m_seen) m_out = ~m_out;
            m_seen = m_db;
            if (m_d2 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db  = m_d2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_d2 = m_d1;
            m_d1 = sw;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (out !== m_out) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t out=%0b model=%0b", $time, out, m_out);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input bit exp);
        n_vec++;
        if (out !== exp || m_out !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t out=%0b model=%0b expected=%0b", name, $time, out, m_out, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        sw    = 1'b0;
        edges(1);
        chk_en = 1'b1;

        // reset held 5 clocks with sw low
        for (int i = 0; i < 4; i++) begin
            check("reset_hold", 1'b0);
            edges(1);
        end
        check("reset_hold_end", 1'b0);

        // release reset with sw already pressed: fresh press, out on 5th edge
        reset = 1'b0; sw = 1'b1;
        edges(4);
        check("first_press_e4", 1'b0);
        edges(1);
        check("first_press_e5", 1'b1);
        for (int i = 0; i < 5; i++) begin
            edges(1);
            check("press_held", 1'b1);
        end

        // release for 5 clocks: out stays on
        sw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            check("release_on", 1'b1);
        end

        // second press turns off five edges later
        sw = 1'b1;
        edges(4);
        check("second_press_e4", 1'b1);
        edges(1);
        check("second_press_e5", 1'b0);
        sw = 1'b0;
        edges(6);
        check("release_off", 1'b0);

        // one-clock glitch is rejected
        sw = 1'b1;
        edges(1);
        sw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            check("glitch_reject", 1'b0);
        end
        // still in OFF_RELEASED: a real press turns on after five edges
        sw = 1'b1;
        edges(4);
        check("post_glitch_e4", 1'b0);
        edges(1);
        check("post_glitch_e5", 1'b1);
        sw = 1'b0;
        edges(6);
        check("post_glitch_release", 1'b1);

        // chatter every clock for 20 clocks: no change
        for (int i = 0; i < 20; i++) begin
            sw = (i % 2 == 0);
            edges(1);
            check("chatter", 1'b1);
        end
        // then hold: exactly one toggle
        sw = 1'b1;
        edges(4);
        check("chatter_hold_e4", 1'b1);
        edges(1);
        check("chatter_hold_e5", 1'b0);
        for (int i = 0; i < 6; i++) begin
            edges(1);
            check("chatter_hold_stay", 1'b0);
        end

        // get to out=1 with sw held
        sw = 1'b0;
        edges(6);
        sw = 1'b1;
        edges(5);
        check("pre_reset_on", 1'b1);
        edges(3);

        // one-clock reset while on and pressed
        reset = 1'b1;
        edges(1);
        check("reset_pulse", 1'b0);
        reset = 1'b0;
        edges(4);
        check("after_reset_e4", 1'b0);
        edges(1);
        check("after_reset_e5", 1'b1);

        // reset in the middle of a debounce run
        sw = 1'b0;
        edges(3);           // debounce counter mid-run on the release
        reset = 1'b1;
        edges(1);
        check("reset_mid_debounce", 1'b0);
        reset = 1'b0;
        edges(8);
        check("reset_mid_idle", 1'b0);

        edges(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
